// File: rtl/n64_demux_ctrl.sv
// n64_demux_ctrl: nDSYNC phase sequencer, frame measurement and demux parameter generation.
// Defining N64_DEMUXCTRL_AUTODEBLUR_EN adds the equal-pair low-resolution detector behind lowres_o.
module n64_demux_ctrl #(
    parameter int color_width      = 7,
    parameter int LINES_PAL_MIN    = 290,
    parameter int PAIR_CNT_W       = 16,
    parameter int DEBLUR_TOL_SHIFT = 4
) (
    input  logic                   nCLK,
    input  logic                   nRST,
    input  logic                   nDSYNC,
    input  logic [color_width-1:0] D_i,
    input  logic [1:0]             deblurmode_i,
    input  logic                   n15bit_i,
    output logic [4:0]             demuxparams_o,
    output logic [1:0]             vinfo_o,
    output logic                   lowres_o
);
    localparam logic [9:0] PAL_MIN = 10'(LINES_PAL_MIN);
    logic [1:0] data_cnt;
    logic       ndo_deblur, nblank_rgb, n15bit_mode, pal, interlaced;
    logic       nvsync_prev, nhsync_prev;
    logic [9:0] line_cnt, line_prev;
    logic       hsync_fall, vsync_fall, lowres_new;
    assign hsync_fall    = ~nDSYNC & nhsync_prev & ~D_i[1];
    assign vsync_fall    = ~nDSYNC & nvsync_prev & ~D_i[3];
    assign demuxparams_o = {data_cnt, ndo_deblur, nblank_rgb, n15bit_mode};
    assign vinfo_o       = {pal, interlaced};
    // bus phase, sync history, line measurement and per-frame demux settings
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            data_cnt    <= 2'b00;
            ndo_deblur  <= 1'b1;
            nblank_rgb  <= 1'b1;
            n15bit_mode <= 1'b1;
            pal         <= 1'b0;
            interlaced  <= 1'b0;
            nvsync_prev <= 1'b1;
            nhsync_prev <= 1'b1;
            line_cnt    <= '0;
            line_prev   <= '0;
        end else begin
            data_cnt <= !nDSYNC ? 2'b01 : (data_cnt == 2'b00 ? 2'b00 : data_cnt + 2'b01);
            if (!nDSYNC) begin
                nvsync_prev <= D_i[3];
                nhsync_prev <= D_i[1];
            end
            if (vsync_fall) begin
                pal         <= line_cnt > PAL_MIN;
                interlaced  <= line_cnt != line_prev;
                line_prev   <= line_cnt;
                line_cnt    <= '0;
                n15bit_mode <= n15bit_i;
                ndo_deblur  <= ~(deblurmode_i == 2'b10 || (deblurmode_i[0] && lowres_new));
            end else if (hsync_fall && line_cnt != 10'h3ff) begin
                line_cnt <= line_cnt + 10'd1;
            end
            nblank_rgb <= ndo_deblur | hsync_fall | (nDSYNC ? nblank_rgb : ~nblank_rgb);
        end
    end
`ifdef N64_DEMUXCTRL_AUTODEBLUR_EN
    localparam logic [PAIR_CNT_W-1:0] PAIR_MAX = '1;
    logic [3*color_width-1:0] cur_rgb, first_rgb;
    logic [PAIR_CNT_W-1:0]    pair_tot, pair_eq, pair_diff;
    logic                     phase, lowres, window;
    assign window     = ~nDSYNC & D_i[3] & D_i[1];
    assign pair_diff  = pair_tot - pair_eq;
    assign lowres_new = (pair_tot != '0) && (pair_diff <= (pair_tot >> DEBLUR_TOL_SHIFT));
    assign lowres_o   = lowres;
    // pixel capture and equal-pair statistics behind the per-frame lowres verdict
    always_ff @(negedge nCLK) begin
        if (!nRST) begin
            cur_rgb   <= '0;
            first_rgb <= '0;
            pair_tot  <= '0;
            pair_eq   <= '0;
            phase     <= 1'b0;
            lowres    <= 1'b0;
        end else begin
            if (nDSYNC && data_cnt != 2'b00)
                cur_rgb <= {cur_rgb[2*color_width-1:0], D_i};
            if (vsync_fall) begin
                lowres   <= lowres_new;
                pair_tot <= '0;
                pair_eq  <= '0;
            end else if (window) begin
                if (phase) begin
                    if (pair_tot != PAIR_MAX)
                        pair_tot <= pair_tot + PAIR_CNT_W'(1);
                    if (cur_rgb == first_rgb && pair_eq != PAIR_MAX)
                        pair_eq <= pair_eq + PAIR_CNT_W'(1);
                end else begin
                    first_rgb <= cur_rgb;
                end
            end
            if (hsync_fall)
                phase <= 1'b0;
            else if (window)
                phase <= ~phase;
        end
    end
`else
    logic unused_bits;
    assign lowres_new  = 1'b0;
    assign lowres_o    = 1'b0;
    assign unused_bits = ^{D_i, PAIR_CNT_W[0], DEBLUR_TOL_SHIFT[0]};
`endif
endmodule

// File: tb/tb_n64_demux_ctrl.sv
// tb_n64_demux_ctrl: directed vectors and sequences for the N64 demux controller.
`timescale 1ns/1ps
module tb_n64_demux_ctrl;
    logic       nCLK = 1'b1, nRST = 1'b0, nDSYNC = 1'b1, n15bit_i = 1'b1;
    logic [6:0] D_i = 7'h0f;
    logic [1:0] deblurmode_i = 2'b00;
    logic [4:0] demuxparams_o;
    logic [1:0] vinfo_o;
    logic       lowres_o;
    int         n_checks = 0, n_fail = 0;

    typedef struct {
        logic       nd;
        logic [4:0] exp;
    } vec_t;
    vec_t vecs[10];

    n64_demux_ctrl dut (
        .nCLK(nCLK), .nRST(nRST), .nDSYNC(nDSYNC), .D_i(D_i),
        .deblurmode_i(deblurmode_i), .n15bit_i(n15bit_i),
        .demuxparams_o(demuxparams_o), .vinfo_o(vinfo_o), .lowres_o(lowres_o)
    );

    always #5 nCLK = ~nCLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // drive between active edges, sample just after the falling edge
    task automatic step(input logic nd, input logic [6:0] d);
        @(posedge nCLK);
        nDSYNC = nd;
        D_i = d;
        @(negedge nCLK);
        #1;
    endtask

    function automatic logic [6:0] sw(input logic vs, input logic hs);
        return {3'b000, vs, 1'b1, hs, 1'b1};
    endfunction

    task automatic group(input logic vs, input logic hs, input logic [6:0] pix);
        step(1'b0, sw(vs, hs));
        for (int i = 0; i < 3; i++) step(1'b1, pix);
    endtask

    task automatic lines(input int n, input int ppl, input bit distinct);
        for (int l = 0; l < n; l++) begin
            group(1'b1, 1'b0, 7'(l + 1));
            for (int p = 0; p < ppl; p++)
                group(1'b1, 1'b1, (distinct && l % 5 == 0) ? 7'(40 + p) : 7'(l + 1));
        end
    endtask

    task automatic vsync();
        group(1'b0, 1'b1, 7'h00);
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'b01111};
        vecs[1] = '{1'b1, 5'b10111};
        vecs[2] = '{1'b1, 5'b11111};
        vecs[3] = '{1'b1, 5'b00111};
        vecs[4] = '{1'b0, 5'b01111};
        vecs[5] = '{1'b1, 5'b10111};
        vecs[6] = '{1'b1, 5'b11111};
        vecs[7] = '{1'b1, 5'b00111};
        vecs[8] = '{1'b1, 5'b00111};
        vecs[9] = '{1'b0, 5'b01111};

        step(1'b1, 7'h0f);
        step(1'b1, 7'h0f);
        check("reset demuxparams", demuxparams_o, 5'b00111);
        check("reset vinfo", vinfo_o, 0);
        check("reset lowres", lowres_o, 0);
        nRST = 1'b1;
        step(1'b1, 7'h0f);
        check("idle after reset", demuxparams_o, 5'b00111);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].nd, 7'h0f);
            check($sformatf("data_cnt vec %0d", i), demuxparams_o, vecs[i].exp);
        end

        vsync();
        check("vinfo empty frame", vinfo_o, 2'b00);
        lines(313, 1, 0); vsync();
        check("vinfo first 313", vinfo_o, 2'b11);
        lines(313, 1, 0); vsync();
        check("vinfo second 313", vinfo_o, 2'b10);
        lines(263, 1, 0); vsync();
        check("vinfo 263", vinfo_o, 2'b01);
        lines(262, 1, 0); vsync();
        check("vinfo 262", vinfo_o, 2'b01);
        lines(263, 1, 0); vsync();
        check("vinfo 263 again", vinfo_o, 2'b01);
        check("ndo_deblur mode off", demuxparams_o[2], 1);

        deblurmode_i = 2'b01;
        lines(20, 16, 0); vsync();
`ifdef N64_DEMUXCTRL_AUTODEBLUR_EN
        check("auto equal ndo_deblur", demuxparams_o[2], 0);
        check("auto equal lowres", lowres_o, 1);
`else
        check("auto equal ndo_deblur", demuxparams_o[2], 1);
        check("auto equal lowres", lowres_o, 0);
`endif

        lines(10, 16, 1);
        n15bit_i = 1'b0;
        check("n15bit held mid-frame", demuxparams_o[0], 1);
        lines(10, 16, 1); vsync();
        check("auto 20pct ndo_deblur", demuxparams_o[2], 1);
        check("auto 20pct lowres", lowres_o, 0);
        check("n15bit at vsync", demuxparams_o[0], 0);

        deblurmode_i = 2'b10;
        lines(4, 4, 0); vsync();
        check("forced ndo_deblur", demuxparams_o[2], 0);
`ifdef N64_DEMUXCTRL_AUTODEBLUR_EN
        check("forced frame lowres", lowres_o, 1);
`else
        check("forced frame lowres", lowres_o, 0);
`endif
        check("nblank after vsync", demuxparams_o[1], 1);

        step(1'b0, sw(1'b1, 1'b0));
        check("nblank hsync", demuxparams_o[1], 1);
        for (int i = 0; i < 3; i++) step(1'b1, 7'h05);
        step(1'b0, sw(1'b1, 1'b1));
        check("nblank pixel 1", demuxparams_o[1], 0);
        for (int i = 0; i < 3; i++) step(1'b1, 7'h05);
        step(1'b0, sw(1'b1, 1'b1));
        check("nblank pixel 2", demuxparams_o[1], 1);
        for (int i = 0; i < 3; i++) step(1'b1, 7'h05);
        step(1'b0, sw(1'b1, 1'b1));
        check("nblank pixel 3", demuxparams_o[1], 0);
        for (int i = 0; i < 3; i++) step(1'b1, 7'h05);

        deblurmode_i = 2'b00;
        step(1'b0, sw(1'b0, 1'b0));
        check("hs+vs ndo/nblank", demuxparams_o[2:1], 2'b11);
        for (int i = 0; i < 3; i++) step(1'b1, 7'h05);
        step(1'b0, sw(1'b1, 1'b1));
        check("nblank held after hs+vs", demuxparams_o, 5'b01110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
